// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Carry-segmented pipelined adder/subtractor. The N-bit carry chain is cut
//   into SEG-bit segments; stage k resolves segment k using the carry that
//   stage k-1 registered. Upper operand bits ride along in skew registers and
//   finished lower sum bits in de-skew registers, so the last stage presents a
//   complete result. The whole pipeline advances in lock-step under a single
//   valid/ready handshake.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand beat present
//   in_ready   pipeline can take a beat this cycle (= !out_valid || out_ready)
//   a, b       N-bit operands
//   op         00 a+b, 01 a-b, 10 a+b+cin, 11 a-b-cin (cin as borrow)
//   cin        carry/borrow in, used by op 10/11 only
//   out_valid  result beat present
//   out_ready  consumer takes the result this cycle
//   sum        N-bit result modulo 2^N
//   cout       carry out of bit N-1 (subtract: 1 = no borrow)
//   ovf        two's-complement overflow

module pipelined_addsub #(
   parameter int N   = 20,
   parameter int SEG = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [1:0]   op,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int unsigned STAGES = (N + SEG - 1) / SEG;
   localparam int unsigned LAST_W = N - (STAGES - 1) * SEG;
   localparam logic [N:0]  ONE    = {{N{1'b0}}, 1'b1};

   // Stage registers: operand skew copies, partial sum, carry, valid.
   logic [N-1:0] a_r [STAGES];
   logic [N-1:0] b_r [STAGES];
   logic [N-1:0] s_r [STAGES];
   logic         c_r [STAGES];
   logic         v_r [STAGES];
   logic         ovf_r;

   // Per-stage inputs (stage 0 from the ports, stage k from stage k-1).
   logic [N-1:0] a_i [STAGES];
   logic [N-1:0] b_i [STAGES];
   logic [N-1:0] s_i [STAGES];
   logic         c_i [STAGES];
   logic         v_i [STAGES];

   // Per-stage results to be registered.
   logic [N-1:0] s_n [STAGES];
   logic         c_n [STAGES];
   logic         ovf_n;

   logic         c0;
   logic         adv;

   assign adv       = !v_r[STAGES-1] || out_ready;
   assign in_ready  = adv;
   assign out_valid = v_r[STAGES-1];
   assign sum       = s_r[STAGES-1];
   assign cout      = c_r[STAGES-1];
   assign ovf       = ovf_r;

   always_comb begin
      c0 = 1'b0;
      unique case (op)
         2'b00:   c0 = 1'b0;
         2'b01:   c0 = 1'b1;
         2'b10:   c0 = cin;
         default: c0 = ~cin;
      endcase
   end

   always_comb begin
      a_i[0] = a;
      b_i[0] = op[0] ? ~b : b;
      s_i[0] = '0;
      c_i[0] = c0;
      v_i[0] = in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
         a_i[k] = a_r[k-1];
         b_i[k] = b_r[k-1];
         s_i[k] = s_r[k-1];
         c_i[k] = c_r[k-1];
         v_i[k] = v_r[k-1];
      end
   end

   // Segment adders. Each works on a masked, shifted copy of the full operand
   // so one loop body covers every stage including a narrower last segment.
   always_comb begin
      int unsigned lo;
      int unsigned w;
      logic [N:0]   mask;
      logic [N:0]   a_seg;
      logic [N:0]   b_seg;
      logic [N:0]   seg;
      logic [N-1:0] mask_n;
      lo     = 0;
      w      = 0;
      mask   = '0;
      a_seg  = '0;
      b_seg  = '0;
      seg    = '0;
      mask_n = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         lo     = k * SEG;
         w      = (k == STAGES - 1) ? LAST_W : SEG;
         mask   = (ONE << w) - ONE;
         a_seg  = ({1'b0, a_i[k]} >> lo) & mask;
         b_seg  = ({1'b0, b_i[k]} >> lo) & mask;
         seg    = a_seg + b_seg + {{N{1'b0}}, c_i[k]};
         c_n[k] = |(seg & (ONE << w));
         mask_n = mask[N-1:0];
         s_n[k] = ((seg[N-1:0] & mask_n) << lo) | (s_i[k] & ~(mask_n << lo));
      end
   end

   // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
   assign ovf_n = a_i[STAGES-1][N-1] ^ b_i[STAGES-1][N-1]
                ^ s_n[STAGES-1][N-1] ^ c_n[STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_r[k] <= '0;
            b_r[k] <= '0;
            s_r[k] <= '0;
            c_r[k] <= 1'b0;
            v_r[k] <= 1'b0;
         end
         ovf_r <= 1'b0;
      end else if (adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_r[k] <= a_i[k];
            b_r[k] <= b_i[k];
            s_r[k] <= s_n[k];
            c_r[k] <= c_n[k];
            v_r[k] <= v_i[k];
         end
         ovf_r <= ovf_n;
      end
   end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, carry-segmented pipelined adder/subtractor. It succeeds the combinational ripple N-bit adder in the low-power multiplier datapath. The N-bit carry chain is split into SEG-bit segments, with one segment resolved per pipeline stage, so long operands meet timing at the cost of latency. The block adds add/subtract/carry-in modes, carry and signed-overflow flags, and a valid/ready handshake with full backpressure.

## Interface
- N, 20: operand/result width, ≥1.
- SEG, 4: segment width, 1 ≤ SEG ≤ N.
- Derived STAGES = ceil(N/SEG). Last segment width = N − (STAGES−1)·SEG.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- op  input  2  00 A+B; 01 A−B; 10 A+B+cin; 11 A−B−cin (cin is a borrow).
- cin  input  1  carry/borrow in; ignored for op 00/01.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts a result this cycle.
- sum  output  N  result, modulo 2^N.
- cout  output  1  carry out of bit N−1. For subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow = carry into bit N−1 XOR cout.

## Operation
- Operand prep at accept: B' = op[0] ? ~b : b.
- Carry-in c0 per op: 00→0, 01→1, 10→cin, 11→~cin.
- Stage k (0..STAGES−1) adds segment k of A and B' plus the carry registered by stage k−1 (c0 for stage 0). It registers the segment sum and the segment carry out.
- Unprocessed upper operand segments travel in skew registers alongside the stage. Completed lower sum segments travel in de-skew registers. The final stage therefore presents all N sum bits of one operation together.
- Stage STAGES−1 also registers the carry into bit N−1 for ovf.
- Each stage has a valid bit, and bubbles propagate as valid=0.
- Global advance: adv = !out_valid || out_ready. When adv=1, all stages shift one step. When adv=0, all pipeline registers hold.
- in_ready = adv, a combinational function of out_valid and out_ready only, with no dependency on in_valid.
- Accept occurs when in_valid && in_ready. If in_valid=0 while adv=1, a bubble enters stage 0.
- Results leave in acceptance order; none are dropped or duplicated.
- SEG=N gives STAGES=1: a single registered adder, same handshake.

## Timing
- Reset (asynchronous assert, takes effect immediately):
  - all valid bits = 0, so out_valid = 0 and in_ready = 1;
  - sum = 0, cout = 0, ovf = 0;
  - all data/skew registers = 0.
- Reset deassertion is synchronous to clk. The first accept is possible on the first rising edge after rst falls.
- Reset mid-operation discards every in-flight beat. No partial result is ever emitted afterwards.
- Latency with no stall: a beat accepted on edge E appears with out_valid=1 after edge E+STAGES−1, i.e. STAGES cycles counting the accept cycle.
- Throughput: one beat per cycle while out_ready=1.
- Stall: when out_valid && !out_ready, then sum/cout/ovf/out_valid hold stable and in_ready=0.
- In the cycle out_ready returns to 1, both transfers happen on the same edge: the output transfers and a new input may be accepted.
- Simultaneous output pop and input accept is always legal. Occupancy never exceeds STAGES.
- cin and op are sampled only at accept. Changing them mid-flight has no effect on accepted beats.

## Test plan
- N=20, SEG=4 (STAGES=5), op 00, a=0xFFFFF, b=0x00001 → after 5 cycles: sum=0x00000, cout=1, ovf=0.
- op 01, a=0x00000, b=0x00001 → sum=0xFFFFF, cout=0, ovf=0. op 01, a=0x80000, b=0x00001 → sum=0x7FFFF, cout=1, ovf=1.
- op 00, a=0x7FFFF, b=0x00001 → sum=0x80000, ovf=1, cout=0. op 10, a=0x0000F, b=0x00000, cin=1 → sum=0x00010. op 11, a=0x00010, b=0x00000, cin=1 → sum=0x0000F, cout=1.
- Throughput and backpressure:
  - 8 back-to-back random beats with out_ready=1 → out_valid high on 8 consecutive cycles, in order, each matching a scoreboard.
  - Then hold out_ready=0 for 3 cycles with the pipeline full → in_ready=0 and outputs stable; nothing lost on release.
- Assert rst for 1 cycle with 3 beats in flight → out_valid=0 and sum=0 immediately, in_ready=1. No stale beat appears in the next 10 cycles.
- N=8, SEG=8 (STAGES=1): a=0xC8, b=0x64, op 00 → sum=0x2C, cout=1, ovf=0 one cycle after accept.
